pc_redirect_unit: RTL and testbench

Fetch-side owner of the program counter. Consumes the 2-bit `pcSel` decision produced by branch resolution in EX, computes the next fetch address, and issues the pipeline flushes needed to squash wrong-path instructions. Holds the PC on load-use stalls and keeps branch and redirect statistics. Sits between the EX stage and the instruction memory address port.

---
 rtl/pc_redirect_unit_pkg.sv | 24 ++
 rtl/pc_target_mux.sv | 42 ++++
 rtl/pc_redirect_unit.sv | 116 +++++++++++
 tb/tb_pc_redirect_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_redirect_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_redirect_unit_pkg
// Description : Shared pcSel encodings, fetch FSM states and reset-PC default
//               used by the PC redirect unit, branch resolution and control.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_redirect_unit_pkg;

    localparam logic [1:0] PCSEL_SEQ  = 2'b00;
    localparam logic [1:0] PCSEL_BR   = 2'b01;
    localparam logic [1:0] PCSEL_JALR = 2'b10;
    localparam logic [1:0] PCSEL_ZERO = 2'b11;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pru_state_t;

endpackage : pc_redirect_unit_pkg
`default_nettype wire

// File: rtl/pc_target_mux.sv
`default_nettype none
// ============================================================================
// Module      : pc_target_mux
// Description : Combinational redirect-target selection and alignment check.
//               Alignment flag is produced only when PC_ALIGN_CHECK_EN is
//               defined; otherwise it is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_target_mux
    import pc_redirect_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      pcSel,
    input  logic [XLEN-1:0] exPc,
    input  logic [XLEN-1:0] exImm,
    input  logic [XLEN-1:0] rs1Val,
    output logic [XLEN-1:0] target,
    output logic            misaligned
);

    logic [XLEN-1:0] w_jalr_sum;

    assign w_jalr_sum = rs1Val + exImm;

    always_comb begin
        target = '0;
        case (pcSel)
            PCSEL_BR:   target = exPc + exImm;
            PCSEL_JALR: target = {w_jalr_sum[XLEN-1:1], 1'b0};
            default:    target = '0;
        endcase
    end

`ifdef PC_ALIGN_CHECK_EN
    assign misaligned = target[1];
`else
    assign misaligned = 1'b0;
`endif

endmodule : pc_target_mux
`default_nettype wire

// File: rtl/pc_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_redirect_unit
// Description : Fetch PC owner: BOOT/RUN/HALT FSM, PC register, redirect
//               flushes, branch/redirect counters. Optional feature macro:
//               PC_ALIGN_CHECK_EN (halt on misaligned redirect target).
// Revision    : 1.0 - initial release
// ============================================================================
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(PC_RESET_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      pcSel,
    input  logic [XLEN-1:0] exPc,
    input  logic [XLEN-1:0] exImm,
    input  logic [XLEN-1:0] rs1Val,
    input  logic            isBranch,
    input  logic            stall,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pcPlus4,
    output logic            pcValid,
    output logic            flushIfId,
    output logic            flushIdEx,
    output logic            misaligned,
    output logic [31:0]     branchCnt,
    output logic [31:0]     redirectCnt
);

    pru_state_t      r_state;
    pru_state_t      w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] w_target;
    logic            w_tgt_misaligned;
    logic            w_redirect;
    logic            w_bad_redirect;
    logic            w_flush;
    logic            r_misaligned;
    logic [31:0]     r_branch_cnt;
    logic [31:0]     r_redirect_cnt;

    pc_target_mux #(
        .XLEN (XLEN)
    ) u_target_mux (
        .pcSel      (pcSel),
        .exPc       (exPc),
        .exImm      (exImm),
        .rs1Val     (rs1Val),
        .target     (w_target),
        .misaligned (w_tgt_misaligned)
    );

    assign w_redirect     = (r_state == ST_RUN) && (pcSel != PCSEL_SEQ);
    assign w_bad_redirect = w_redirect && w_tgt_misaligned;

    // A redirect overrides stall: the stalled instruction is being squashed.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_flush     = 1'b0;
        case (r_state)
            ST_BOOT: w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (w_redirect) begin
                    w_flush = 1'b1;
                    if (w_bad_redirect) begin
                        w_state_nxt = ST_HALT;
                    end else begin
                        w_pc_nxt = w_target;
                    end
                end else if (!stall) begin
                    w_pc_nxt = r_pc + XLEN'(4);
                end
            end
            ST_HALT: w_flush = 1'b1;
            default: w_state_nxt = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_BOOT;
            r_pc           <= RESET_PC;
            r_misaligned   <= 1'b0;
            r_branch_cnt   <= '0;
            r_redirect_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if ((r_state == ST_RUN) && isBranch && !stall) begin
                r_branch_cnt <= r_branch_cnt + 32'd1;
            end
            if (w_redirect) begin
                r_redirect_cnt <= r_redirect_cnt + 32'd1;
            end
            if (w_bad_redirect) begin
                r_misaligned <= 1'b1;
            end
        end
    end

    assign pc          = r_pc;
    assign pcPlus4     = r_pc + XLEN'(4);
    assign pcValid     = (r_state == ST_RUN);
    assign flushIfId   = w_flush;
    assign flushIdEx   = w_flush;
    assign misaligned  = r_misaligned;
    assign branchCnt   = r_branch_cnt;
    assign redirectCnt = r_redirect_cnt;

endmodule : pc_redirect_unit
`default_nettype wire

// File: tb/tb_pc_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_redirect_unit
// Description : Self-checking bench for pc_redirect_unit: directed table,
//               hand sequences and randomized stimulus against a spec model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_redirect_unit;

    localparam int          XLEN = 32;
    localparam logic [31:0] RPC  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  pcSel = 2'b00;
    logic [31:0] exPc = '0, exImm = '0, rs1Val = '0;
    logic        isBranch = 1'b0, stall = 1'b0;
    logic [31:0] pc, pcPlus4, branchCnt, redirectCnt;
    logic        pcValid, flushIfId, flushIdEx, misaligned;

    pc_redirect_unit #(.XLEN(XLEN), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .pcSel(pcSel), .exPc(exPc), .exImm(exImm),
        .rs1Val(rs1Val), .isBranch(isBranch), .stall(stall), .pc(pc),
        .pcPlus4(pcPlus4), .pcValid(pcValid), .flushIfId(flushIfId),
        .flushIdEx(flushIdEx), .misaligned(misaligned), .branchCnt(branchCnt),
        .redirectCnt(redirectCnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: phase 0 = booting, 1 = running, 2 = halted
    int          m_phase;
    logic [31:0] m_pc, m_bc, m_rc;
    logic        m_mis;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] spec_target(input logic [1:0] s, input logic [31:0] p,
                                                input logic [31:0] imm, input logic [31:0] r);
        logic [31:0] sum;
        sum = r + imm;
        case (s)
            2'b01:   return p + imm;
            2'b10:   return sum & 32'hFFFF_FFFE;
            default: return 32'h0;
        endcase
    endfunction

    // Entered and left at a falling edge.
    task automatic step(input logic [1:0] s, input logic [31:0] p, input logic [31:0] imm,
                        input logic [31:0] r, input logic b, input logic st);
        logic        redir, bad;
        logic [31:0] tgt;
        pcSel = s; exPc = p; exImm = imm; rs1Val = r; isBranch = b; stall = st;
        #1;
        redir = (m_phase == 1) && (s != 2'b00);
        tgt   = spec_target(s, p, imm, r);
        bad   = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        bad = redir && tgt[1];
`endif
        chk("pc_pre", pc, m_pc);
        chk("pcPlus4", pcPlus4, m_pc + 32'd4);
        chk("pcValid", pcValid, m_phase == 1);
        chk("flushIfId", flushIfId, redir || (m_phase == 2));
        chk("flushIdEx", flushIdEx, redir || (m_phase == 2));
        if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (b && !st) m_bc = m_bc + 1;
            if (redir) begin
                m_rc = m_rc + 1;
                if (bad) begin
                    m_mis   = 1'b1;
                    m_phase = 2;
                end else begin
                    m_pc = tgt;
                end
            end else if (!st) begin
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        chk("pc_post", pc, m_pc);
        chk("branchCnt", branchCnt, m_bc);
        chk("redirectCnt", redirectCnt, m_rc);
        chk("misaligned", misaligned, m_mis);
        @(negedge clk);
    endtask

    task automatic idle();
        step(2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    // Reset is asserted together with a live redirect to show it has priority.
    task automatic do_reset();
        rst = 1'b1; pcSel = 2'b01; exPc = 32'h1234_5678; exImm = 32'h4;
        isBranch = 1'b1; stall = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_phase = 0; m_pc = RPC; m_bc = 0; m_rc = 0; m_mis = 1'b0;
        chk("rst_pc", pc, RPC);
        chk("rst_pcPlus4", pcPlus4, RPC + 32'd4);
        chk("rst_pcValid", pcValid, 1'b0);
        chk("rst_flushIfId", flushIfId, 1'b0);
        chk("rst_flushIdEx", flushIdEx, 1'b0);
        chk("rst_misaligned", misaligned, 1'b0);
        chk("rst_branchCnt", branchCnt, 32'd0);
        chk("rst_redirectCnt", redirectCnt, 32'd0);
        @(negedge clk);
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] p;
        logic [31:0] imm;
        logic [31:0] r;
        logic        st;
        logic [31:0] nxt;
    } vec_t;

    vec_t vt[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vt[0] = '{2'b01, 32'h0000_0100, 32'hFFFF_FFF0, 32'h0,         1'b0, 32'h0000_00F0};
        vt[1] = '{2'b10, 32'h0,         32'h0000_0004, 32'h0000_0203, 1'b1, 32'h0000_0206};
        vt[2] = '{2'b11, 32'h0000_0500, 32'h0000_0040, 32'h0000_0777, 1'b0, 32'h0000_0000};
        vt[3] = '{2'b01, 32'h0000_1000, 32'h0000_0020, 32'h0,         1'b1, 32'h0000_1020};
        vt[4] = '{2'b10, 32'h0,         32'hFFFF_FFFF, 32'h0000_1001, 1'b0, 32'h0000_1000};

        // Boot then sequential fetch 0, 4, 8, 12
        do_reset();
        idle();
        for (int k = 0; k < 4; k++) begin
            chk("seq_pc", pc, 32'(k * 4));
            idle();
        end

        // Directed redirect table
        do_reset();
        idle();
`ifndef PC_ALIGN_CHECK_EN
        for (int i = 0; i < 5; i++) begin
            step(vt[i].sel, vt[i].p, vt[i].imm, vt[i].r, 1'b0, vt[i].st);
            chk("tbl_next_pc", pc, vt[i].nxt);
            chk("tbl_redirectCnt", redirectCnt, 32'(i + 1));
        end
`else
        for (int i = 0; i < 5; i++) begin
            if (i != 1) begin
                step(vt[i].sel, vt[i].p, vt[i].imm, vt[i].r, 1'b0, vt[i].st);
                chk("tbl_next_pc", pc, vt[i].nxt);
            end
        end
`endif

        // Stall hold at 0x40, then ten branches
        do_reset();
        idle();
        step(2'b01, 32'h40, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
            chk("stall_pc", pc, 32'h40);
        end
        idle();
        chk("after_stall_pc", pc, 32'h44);
        for (int k = 0; k < 10; k++) step(2'b00, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("branchCnt10", branchCnt, 32'd10);

        // Wrap at top of address space, and pcSel=11 from nonzero pc
        step(2'b01, 32'hFFFF_FFF0, 32'hC, 32'h0, 1'b0, 1'b0);
        chk("top_pc", pc, 32'hFFFF_FFFC);
        idle();
        chk("wrap_pc", pc, 32'h0);
        idle();
        step(2'b11, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("zero_pc", pc, 32'h0);

        // Misaligned redirect target
        do_reset();
        idle();
        idle();
`ifdef PC_ALIGN_CHECK_EN
        step(2'b01, 32'h10, 32'h2, 32'h0, 1'b0, 1'b0);
        chk("mis_flag", misaligned, 1'b1);
        chk("mis_pc_held", pc, 32'h4);
        chk("mis_pcValid", pcValid, 1'b0);
        chk("mis_flush", flushIfId, 1'b1);
        idle();
        idle();
        chk("halt_pc", pc, 32'h4);
        do_reset();
        idle();
`else
        step(2'b01, 32'h10, 32'h2, 32'h0, 1'b0, 1'b0);
        chk("unchecked_pc", pc, 32'h12);
        chk("unchecked_mis", misaligned, 1'b0);
`endif

        // Randomized stimulus against the model
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                step(($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                     $urandom, $urandom, $urandom,
                     1'($urandom), ($urandom_range(0, 3) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_pc_redirect_unit
`default_nettype wire
